custom_axi_regs: RTL and testbench

CUSTOM_AXI_REGS -- requirements
Module: custom_axi_regs

---
 rtl/custom_axi_ip_pkg.sv | 35 +++
 rtl/custom_axi_regs_if.sv | 37 +++
 rtl/custom_axi_regs.sv | 216 +++++++++++++++++++++
 tb/tb_custom_axi_regs.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/custom_axi_ip_pkg.sv
// Shared definitions for the custom IP register front-end: register offsets,
// AXI response codes, the core's status encoding and internal selector/state types.
package custom_axi_ip_pkg;

  localparam int unsigned OFS_CTRL   = 32'h00;
  localparam int unsigned OFS_DIN    = 32'h04;
  localparam int unsigned OFS_DOUT   = 32'h08;
  localparam int unsigned OFS_STATUS = 32'h0C;
  localparam int unsigned OFS_IRQ    = 32'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    STATUS_IDLE  = 2'd0,
    STATUS_BUSY  = 2'd1,
    STATUS_DONE  = 2'd2,
    STATUS_ERROR = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_DIN,
    SEL_DOUT,
    SEL_STATUS,
    SEL_IRQ,
    SEL_NONE
  } reg_sel_e;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

endpackage

// File: rtl/custom_axi_regs_if.sv
// AXI4-Lite slave bus bundle for custom_axi_regs; master drives requests, slave responds.
interface custom_axi_regs_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/custom_axi_regs.sv
// AXI4-Lite register front-end for the custom IP core (DIN/CTRL out, DOUT/STATUS in).
// Define CUSTOM_AXI_REGS_IRQ_EN to add the IRQ register at 0x10 and the irq_o output.
//
//   state   | meaning
//   WR_IDLE | filling the AW/W buffers; commits the cycle both are full
//   WR_RESP | bvalid high, waiting for bready; buffers free on the handshake
module custom_axi_regs
  import custom_axi_ip_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  custom_axi_regs_if.slave      axi,
  output logic [DATA_WIDTH-1:0] hw_din_o,
  output logic                  hw_enable_o,
  input  logic [DATA_WIDTH-1:0] hw_dout_i,
  input  logic [1:0]            hw_enable_out_i,
  input  logic [1:0]            hw_status_i
`ifdef CUSTOM_AXI_REGS_IRQ_EN
  ,
  output logic                  irq_o
`endif
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int WIDX_WIDTH = ADDR_WIDTH - 2;

  function automatic reg_sel_e decode(input logic [WIDX_WIDTH-1:0] widx);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (32'(widx) == (OFS_CTRL >> 2))        sel = SEL_CTRL;
    else if (32'(widx) == (OFS_DIN >> 2))    sel = SEL_DIN;
    else if (32'(widx) == (OFS_DOUT >> 2))   sel = SEL_DOUT;
    else if (32'(widx) == (OFS_STATUS >> 2)) sel = SEL_STATUS;
`ifdef CUSTOM_AXI_REGS_IRQ_EN
    else if (32'(widx) == (OFS_IRQ >> 2))    sel = SEL_IRQ;
`endif
    return sel;
  endfunction

  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_full_q, w_full_q;
  logic [WIDX_WIDTH-1:0] aw_widx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  reg_sel_e              wr_sel, rd_sel;
  logic [DATA_WIDTH-1:0] din_q, rdata_q, status_word;
  logic [1:0]            bresp_q, rresp_q;
  logic                  rvalid_q, enable_q;
  status_e               hw_status;
  logic                  unused_addr_lsbs;

  // Byte-lane bits of the address are ignored: all registers are word aligned.
  assign unused_addr_lsbs = ^{axi.s_axi_awaddr[1:0], axi.s_axi_araddr[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) wr_state_q <= WR_IDLE;
    else       wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    if (wr_state_q == WR_IDLE) begin
      if (aw_full_q && w_full_q) wr_state_d = WR_RESP;
    end else if (axi.s_axi_bready) begin
      wr_state_d = WR_IDLE;
    end
  end

  always_comb begin
    axi.s_axi_bvalid = 1'b0;
    commit           = 1'b0;
    if (wr_state_q == WR_RESP) axi.s_axi_bvalid = 1'b1;
    else                       commit = aw_full_q && w_full_q;
  end

  assign axi.s_axi_awready = !rst_i && !aw_full_q && !axi.s_axi_bvalid;
  assign axi.s_axi_wready  = !rst_i && !w_full_q && !axi.s_axi_bvalid;
  assign axi.s_axi_arready = !rst_i && !rvalid_q;

  assign aw_hs = axi.s_axi_awvalid && axi.s_axi_awready;
  assign w_hs  = axi.s_axi_wvalid && axi.s_axi_wready;
  assign b_hs  = axi.s_axi_bvalid && axi.s_axi_bready;
  assign ar_hs = axi.s_axi_arvalid && axi.s_axi_arready;
  assign r_hs  = rvalid_q && axi.s_axi_rready;

  assign wr_sel = decode(aw_widx_q);
  assign rd_sel = decode(axi.s_axi_araddr[ADDR_WIDTH-1:2]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_widx_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (b_hs) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_widx_q <= axi.s_axi_awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= axi.s_axi_wdata;
        w_strb_q <= axi.s_axi_wstrb;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      din_q    <= '0;
      enable_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      enable_q <= 1'b0;
      if (commit) begin
        bresp_q <= RESP_SLVERR;
        case (wr_sel)
          SEL_CTRL: begin
            bresp_q  <= RESP_OKAY;
            enable_q <= w_strb_q[0] && w_data_q[0];
          end
          SEL_DIN: begin
            bresp_q <= RESP_OKAY;
            for (int i = 0; i < STRB_WIDTH; i++) begin
              if (w_strb_q[i]) din_q[8*i +: 8] <= w_data_q[8*i +: 8];
            end
          end
`ifdef CUSTOM_AXI_REGS_IRQ_EN
          SEL_IRQ: bresp_q <= RESP_OKAY;
`endif
          default: ;
        endcase
      end
    end
  end

  assign hw_status   = status_e'(hw_status_i);
  assign status_word = DATA_WIDTH'({hw_enable_out_i, 6'b0, hw_status});

`ifdef CUSTOM_AXI_REGS_IRQ_EN
  logic irq_pend_q, irq_mask_q, en_out_prev_q, irq_q;
  logic irq_set, irq_wr, pend_d, mask_d;

  assign irq_set = hw_enable_out_i[0] && !en_out_prev_q;
  assign irq_wr  = commit && (wr_sel == SEL_IRQ) && w_strb_q[0];

  // A new edge from the core beats a simultaneous W1C so no event is lost.
  always_comb begin
    pend_d = irq_pend_q;
    mask_d = irq_mask_q;
    if (irq_wr) begin
      if (w_data_q[0]) pend_d = 1'b0;
      mask_d = w_data_q[1];
    end
    if (irq_set) pend_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_pend_q    <= 1'b0;
      irq_mask_q    <= 1'b0;
      en_out_prev_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      irq_pend_q    <= pend_d;
      irq_mask_q    <= mask_d;
      en_out_prev_q <= hw_enable_out_i[0];
      irq_q         <= pend_d && mask_d;
    end
  end

  assign irq_o = irq_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= RESP_OKAY;
      case (rd_sel)
        SEL_CTRL:   rdata_q <= '0;
        SEL_DIN:    rdata_q <= din_q;
        SEL_DOUT:   rdata_q <= hw_dout_i;
        SEL_STATUS: rdata_q <= status_word;
`ifdef CUSTOM_AXI_REGS_IRQ_EN
        SEL_IRQ:    rdata_q <= DATA_WIDTH'({irq_mask_q, irq_pend_q});
`endif
        default: begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end
      endcase
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
    end
  end

  assign axi.s_axi_bresp  = bresp_q;
  assign axi.s_axi_rdata  = rdata_q;
  assign axi.s_axi_rresp  = rresp_q;
  assign axi.s_axi_rvalid = rvalid_q;
  assign hw_din_o         = din_q;
  assign hw_enable_o      = enable_q;

endmodule

// File: tb/tb_custom_axi_regs.sv
// Randomized self-checking bench for custom_axi_regs against a register-map model.
// Build with CUSTOM_AXI_REGS_IRQ_EN defined to also exercise the IRQ register.
module tb_custom_axi_regs;
  import custom_axi_ip_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] hw_din_o;
  logic        hw_enable_o;
  logic [31:0] hw_dout_i;
  logic [1:0]  hw_enable_out_i;
  logic [1:0]  hw_status_i;
`ifdef CUSTOM_AXI_REGS_IRQ_EN
  logic        irq_o;
  logic        m_pend, m_mask;
`endif

  always #5 clk_i = ~clk_i;

  custom_axi_regs_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) axi ();

  custom_axi_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .axi             (axi),
    .hw_din_o        (hw_din_o),
    .hw_enable_o     (hw_enable_o),
    .hw_dout_i       (hw_dout_i),
    .hw_enable_out_i (hw_enable_out_i),
    .hw_status_i     (hw_status_i)
`ifdef CUSTOM_AXI_REGS_IRQ_EN
    ,
    .irq_o           (irq_o)
`endif
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          en_high_cycles = 0;
  logic [31:0] m_din;

  always @(negedge clk_i) if (hw_enable_o) en_high_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Register map as a table: word index -> write response / read value.
  function automatic logic [1:0] model_wresp(input logic [4:0] a);
    case (a[4:2])
      3'd0, 3'd1: return RESP_OKAY;
`ifdef CUSTOM_AXI_REGS_IRQ_EN
      3'd4:       return RESP_OKAY;
`endif
      default:    return RESP_SLVERR;
    endcase
  endfunction

  task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    d = 32'h0;
    r = RESP_OKAY;
    case (a[4:2])
      3'd0: d = 32'h0;
      3'd1: d = m_din;
      3'd2: d = hw_dout_i;
      3'd3: d = {22'h0, hw_enable_out_i, 6'h0, hw_status_i};
`ifdef CUSTOM_AXI_REGS_IRQ_EN
      3'd4: d = {30'h0, m_mask, m_pend};
`endif
      default: r = RESP_SLVERR;
    endcase
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a[4:2] == 3'd1) begin
      for (int i = 0; i < 4; i++) if (s[i]) m_din[8*i +: 8] = d[8*i +: 8];
    end
`ifdef CUSTOM_AXI_REGS_IRQ_EN
    if (a[4:2] == 3'd4 && s[0]) begin
      if (d[0]) m_pend = 1'b0;
      m_mask = d[1];
    end
`endif
  endtask

  task automatic randomize_hw();
    hw_dout_i   = $urandom();
    hw_status_i = 2'($urandom_range(0, 3));
`ifdef CUSTOM_AXI_REGS_IRQ_EN
    hw_enable_out_i[1] = 1'($urandom_range(0, 1));
`else
    hw_enable_out_i = 2'($urandom_range(0, 3));
`endif
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input bit aw_first, input int gap, input int bdelay);
    bit         aw_done = 1'b0;
    bit         w_done = 1'b0;
    logic [1:0] exp_resp;
    logic       exp_start;
    int         en_before;
    int         n;
    exp_resp  = model_wresp(addr);
    exp_start = (addr[4:2] == 3'd0) && strb[0] && data[0];
    en_before = en_high_cycles;
    @(posedge clk_i); #1;
    fork
      begin
        int k;
        if (!aw_first) repeat (gap) begin @(posedge clk_i); #1; end
        axi.s_axi_awaddr  = addr;
        axi.s_axi_awvalid = 1'b1;
        for (k = 0; k < 40; k++) begin
          @(negedge clk_i);
          if (axi.s_axi_awready) break;
        end
        check("aw_accepted", 32'(k < 40), 32'd1);
        @(posedge clk_i); #1;
        axi.s_axi_awvalid = 1'b0;
        aw_done = 1'b1;
        @(negedge clk_i);
        if (!w_done) check("awready_low_when_full", 32'(axi.s_axi_awready), 32'd0);
      end
      begin
        int k;
        if (aw_first) repeat (gap) begin @(posedge clk_i); #1; end
        axi.s_axi_wdata  = data;
        axi.s_axi_wstrb  = strb;
        axi.s_axi_wvalid = 1'b1;
        for (k = 0; k < 40; k++) begin
          @(negedge clk_i);
          if (axi.s_axi_wready) break;
        end
        check("w_accepted", 32'(k < 40), 32'd1);
        @(posedge clk_i); #1;
        axi.s_axi_wvalid = 1'b0;
        w_done = 1'b1;
        @(negedge clk_i);
        if (!aw_done) check("wready_low_when_full", 32'(axi.s_axi_wready), 32'd0);
      end
    join
    for (n = 0; n < 20; n++) begin
      if (n > 0) @(negedge clk_i);
      else @(negedge clk_i);
      if (axi.s_axi_bvalid) break;
    end
    check("bvalid_seen", 32'(n), 32'd0);
    check("hw_enable_after_commit", 32'(hw_enable_o), 32'(exp_start));
    repeat (bdelay) begin
      @(negedge clk_i);
      check("bvalid_held", 32'(axi.s_axi_bvalid), 32'd1);
      check("awready_during_b", 32'(axi.s_axi_awready), 32'd0);
      check("wready_during_b", 32'(axi.s_axi_wready), 32'd0);
    end
    check("bresp", 32'(axi.s_axi_bresp), 32'(exp_resp));
    axi.s_axi_bready = 1'b1;
    @(posedge clk_i); #1;
    axi.s_axi_bready = 1'b0;
    model_write(addr, data, strb);
    @(negedge clk_i);
    check("bvalid_dropped", 32'(axi.s_axi_bvalid), 32'd0);
    check("hw_din", hw_din_o, m_din);
    check("start_pulse_cycles", 32'(en_high_cycles - en_before), 32'(exp_start));
  endtask

  task automatic axi_read(input logic [4:0] addr, input int rdelay);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          n;
    @(posedge clk_i); #1;
    model_read(addr, exp_data, exp_resp);
    axi.s_axi_araddr  = addr;
    axi.s_axi_arvalid = 1'b1;
    for (n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (axi.s_axi_arready) break;
    end
    check("ar_accepted", 32'(n < 40), 32'd1);
    @(posedge clk_i); #1;
    axi.s_axi_arvalid = 1'b0;
    randomize_hw();
    for (n = 0; n < 10; n++) begin
      @(negedge clk_i);
      if (axi.s_axi_rvalid) break;
    end
    check("rvalid_next_cycle", 32'(n), 32'd0);
    check("rdata", axi.s_axi_rdata, exp_data);
    check("rresp", 32'(axi.s_axi_rresp), 32'(exp_resp));
    repeat (rdelay) begin
      @(negedge clk_i);
      check("rvalid_held", 32'(axi.s_axi_rvalid), 32'd1);
      check("rdata_stable", axi.s_axi_rdata, exp_data);
      check("arready_during_r", 32'(axi.s_axi_arready), 32'd0);
    end
    axi.s_axi_rready = 1'b1;
    @(posedge clk_i); #1;
    axi.s_axi_rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata = '0;  axi.s_axi_wstrb = '0; axi.s_axi_wvalid = 1'b0;
    axi.s_axi_bready = 1'b0;
    axi.s_axi_araddr = '0; axi.s_axi_arvalid = 1'b0; axi.s_axi_rready = 1'b0;
    hw_dout_i = 32'h0; hw_status_i = 2'b00; hw_enable_out_i = 2'b00;
    m_din = 32'h0;
`ifdef CUSTOM_AXI_REGS_IRQ_EN
    m_pend = 1'b0; m_mask = 1'b0;
`endif
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_awready", 32'(axi.s_axi_awready), 32'd0);
    check("rst_wready", 32'(axi.s_axi_wready), 32'd0);
    check("rst_arready", 32'(axi.s_axi_arready), 32'd0);
    check("rst_bvalid", 32'(axi.s_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(axi.s_axi_rvalid), 32'd0);
    check("rst_resp", 32'({axi.s_axi_bresp, axi.s_axi_rresp}), 32'd0);
    check("rst_rdata", axi.s_axi_rdata, 32'd0);
    check("rst_din", hw_din_o, 32'd0);
    check("rst_enable", 32'(hw_enable_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_readies", 32'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}), 32'h7);

    axi_write(5'h04, 32'hDEADBEEF, 4'hF, 1'b1, 3, 0);
    check("din_full_write", hw_din_o, 32'hDEADBEEF);
    axi_read(5'h04, 1);
    axi_write(5'h04, 32'h0000AB00, 4'b0010, 1'b0, 1, 0);
    check("din_byte_write", hw_din_o, 32'hDEADABEF);
    axi_write(5'h00, 32'h1, 4'h1, 1'b1, 0, 0);
    axi_read(5'h00, 0);
    axi_write(5'h08, 32'h12345678, 4'hF, 1'b0, 2, 1);
    axi_read(5'h14, 0);
    check("din_after_slverr", hw_din_o, 32'hDEADABEF);
    axi_write(5'h05, 32'hCAFEF00D, 4'hF, 1'b1, 0, 5);
    axi_write(5'h04, 32'h0BADC0DE, 4'b1001, 1'b0, 0, 0);
    axi_read(5'h0C, 2);
    axi_read(5'h0B, 0);

    // Read of DIN launched so its AR handshake lands on the write commit edge.
    fork
      axi_write(5'h04, 32'h12345678, 4'hF, 1'b1, 0, 1);
      begin
        @(posedge clk_i);
        axi_read(5'h04, 1);
      end
    join

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 1)
        axi_write(5'($urandom_range(0, 31)), $urandom(), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 3));
      else begin
        randomize_hw();
        axi_read(5'($urandom_range(0, 31)), $urandom_range(0, 3));
      end
    end

`ifdef CUSTOM_AXI_REGS_IRQ_EN
    hw_enable_out_i[0] = 1'b0;
    axi_write(5'h10, 32'h2, 4'h1, 1'b1, 0, 0);
    @(posedge clk_i); #1;
    hw_enable_out_i[0] = 1'b1;
    @(negedge clk_i);
    check("irq_before_edge_seen", 32'(irq_o), 32'd0);
    @(negedge clk_i);
    check("irq_raised", 32'(irq_o), 32'd1);
    m_pend = 1'b1;
    axi_read(5'h10, 0);
    axi_write(5'h10, 32'h3, 4'h1, 1'b0, 1, 0);
    check("irq_cleared", 32'(irq_o), 32'd0);
    axi_read(5'h10, 0);
`endif

    // Reset with an AW buffered and a read response outstanding.
    @(posedge clk_i); #1;
    axi.s_axi_awaddr = 5'h04; axi.s_axi_awvalid = 1'b1;
    axi.s_axi_araddr = 5'h08; axi.s_axi_arvalid = 1'b1;
    @(posedge clk_i); #1;
    axi.s_axi_awvalid = 1'b0; axi.s_axi_arvalid = 1'b0;
    @(negedge clk_i);
    check("pending_rvalid", 32'(axi.s_axi_rvalid), 32'd1);
    rst_i = 1'b1;
    #1;
    check("in_rst_readies", 32'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}), 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rst_drops_rvalid", 32'(axi.s_axi_rvalid), 32'd0);
    check("rst_clears_rdata", axi.s_axi_rdata, 32'd0);
    check("rst_clears_din", hw_din_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    m_din = 32'h0;
    @(negedge clk_i);
    check("release_readies", 32'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}), 32'h7);
    @(posedge clk_i); #1;
    axi.s_axi_wdata = 32'hFFFFFFFF; axi.s_axi_wstrb = 4'hF; axi.s_axi_wvalid = 1'b1;
    @(posedge clk_i); #1;
    axi.s_axi_wvalid = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      check("stale_aw_dropped", 32'(axi.s_axi_bvalid), 32'd0);
    end
    check("din_untouched", hw_din_o, m_din);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
